// File: rtl/conv_encoder_punct.sv
// Rate-1/2 K=7 convolutional encoder with 2/3 and 3/4 puncturing.
// Emits a serial coded stream; stalls the input while a second kept bit drains.
module conv_encoder_punct #(
    parameter logic [6:0] G0 = 7'o133,
    parameter logic [6:0] G1 = 7'o171
) (
    input  logic       Clock,
    input  logic       Reset,
    input  logic       Start,
    input  logic [1:0] Rate,
    input  logic       Input,
    input  logic       InValid,
    output logic       InReady,
    output logic       Output,
    output logic       OutValid
);

    localparam int unsigned SR_W   = 6;
    localparam int unsigned PH_W   = 2;
    localparam int unsigned RATE_W = 2;

    typedef enum logic [RATE_W-1:0] {
        RATE_1_2  = 2'b00,
        RATE_2_3  = 2'b01,
        RATE_3_4  = 2'b10,
        RATE_RSVD = 2'b11
    } rate_t;

    // ST_PEND: the B bit of the last accept still has to go out.
    typedef enum logic {
        ST_READY = 1'b0,
        ST_PEND  = 1'b1
    } state_t;

    state_t            state_q, state_d;
    logic [SR_W-1:0]   sr_q, sr_d;          // sr_q[SR_W-1] is s1, sr_q[0] is s6
    logic [PH_W-1:0]   phase_q, phase_d;
    rate_t             rate_q, rate_d;
    logic              pend_bit_q, pend_bit_d;
    logic              out_q, out_d;
    logic              out_valid_q, out_valid_d;

    logic [SR_W:0]     tap_vec;
    logic              code_a;
    logic              code_b;
    logic              keep_a;
    logic              keep_b;
    logic              phase_last;

    // Generator taps: MSB weights the incoming bit, LSB weights s6.
    always_comb begin
        tap_vec = {Input, sr_q};
        code_a  = ^(tap_vec & G0);
        code_b  = ^(tap_vec & G1);
    end

    // Puncture pattern for the latched rate; reserved rate behaves as 1/2.
    always_comb begin
        keep_a     = 1'b1;
        keep_b     = 1'b1;
        phase_last = 1'b1;
        case (rate_q)
            RATE_2_3: begin
                keep_b     = (phase_q == PH_W'(0));
                phase_last = (phase_q == PH_W'(1));
            end
            RATE_3_4: begin
                keep_a     = (phase_q != PH_W'(2));
                keep_b     = (phase_q != PH_W'(1));
                phase_last = (phase_q == PH_W'(2));
            end
            default: begin
                keep_a     = 1'b1;
                keep_b     = 1'b1;
                phase_last = 1'b1;
            end
        endcase
    end

    assign InReady = (state_q == ST_READY) & ~Start;

    // Next-state and output logic; Start overrides everything, dropping a pending bit.
    always_comb begin
        state_d     = state_q;
        sr_d        = sr_q;
        phase_d     = phase_q;
        rate_d      = rate_q;
        pend_bit_d  = pend_bit_q;
        out_d       = out_q;
        out_valid_d = 1'b0;

        if (Start) begin
            state_d = ST_READY;
            sr_d    = '0;
            phase_d = '0;
            rate_d  = rate_t'(Rate);
        end else begin
            case (state_q)
                ST_PEND: begin
                    out_d       = pend_bit_q;
                    out_valid_d = 1'b1;
                    state_d     = ST_READY;
                end
                default: begin
                    if (InValid) begin
                        sr_d        = {Input, sr_q[SR_W-1:1]};
                        phase_d     = phase_last ? '0 : PH_W'(phase_q + PH_W'(1));
                        out_d       = keep_a ? code_a : code_b;
                        out_valid_d = 1'b1;
                        if (keep_a && keep_b) begin
                            state_d    = ST_PEND;
                            pend_bit_d = code_b;
                        end
                    end
                end
            endcase
        end
    end

    always_ff @(posedge Clock or negedge Reset) begin
        if (!Reset) begin
            state_q     <= ST_READY;
            sr_q        <= '0;
            phase_q     <= '0;
            rate_q      <= RATE_1_2;
            pend_bit_q  <= 1'b0;
            out_q       <= 1'b0;
            out_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            sr_q        <= sr_d;
            phase_q     <= phase_d;
            rate_q      <= rate_d;
            pend_bit_q  <= pend_bit_d;
            out_q       <= out_d;
            out_valid_q <= out_valid_d;
        end
    end

    assign Output   = out_q;
    assign OutValid = out_valid_q;

endmodule

// File: tb/tb_conv_encoder_punct.sv
// Directed bench for conv_encoder_punct: hand-derived coded streams per rate,
// stall pattern, Start-while-pending and asynchronous reset behaviour.
module tb_conv_encoder_punct;

    logic       Clock;
    logic       Reset;
    logic       Start;
    logic [1:0] Rate;
    logic       Input;
    logic       InValid;
    logic       InReady;
    logic       Output;
    logic       OutValid;

    int n_vec = 0;
    int n_err = 0;

    conv_encoder_punct dut (
        .Clock    (Clock),
        .Reset    (Reset),
        .Start    (Start),
        .Rate     (Rate),
        .Input    (Input),
        .InValid  (InValid),
        .InReady  (InReady),
        .Output   (Output),
        .OutValid (OutValid)
    );

    initial Clock = 1'b0;
    always #5 Clock = ~Clock;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge Clock);
        #1;
    endtask

    // bits/exp/rdy are MSB-first: element 0 is the leftmost literal bit.
    task automatic run_stream(input string tag, input logic [1:0] rate,
                              input logic [31:0] bits, input int nbits,
                              input logic [31:0] exp, input logic [31:0] rdy,
                              input int nexp);
        int  idx;
        logic acc;
        Start   = 1'b1;
        Rate    = rate;
        InValid = 1'b1;
        Input   = 1'b1;
        #1;
        check({tag, " ready_at_start"}, 32'(InReady), 32'd0);
        tick();
        check({tag, " valid_after_start"}, 32'(OutValid), 32'd0);
        Start = 1'b0;
        Rate  = 2'(rate + 2'd1);
        idx   = 0;
        for (int k = 0; k < nexp; k++) begin
            InValid = (idx < nbits);
            Input   = (idx < nbits) ? bits[nbits-1-idx] : 1'b0;
            #1;
            check($sformatf("%s ready[%0d]", tag, k), 32'(InReady), 32'(rdy[nexp-1-k]));
            acc = InValid & InReady;
            tick();
            if (acc) idx++;
            check($sformatf("%s out[%0d]", tag, k), 32'(Output), 32'(exp[nexp-1-k]));
            check($sformatf("%s valid[%0d]", tag, k), 32'(OutValid), 32'd1);
        end
        check({tag, " consumed"}, 32'(idx), 32'(nbits));
        InValid = 1'b0;
        Input   = 1'b0;
        tick();
        check({tag, " idle_valid"}, 32'(OutValid), 32'd0);
        check({tag, " idle_hold"}, 32'(Output), 32'(exp[0]));
    endtask

    initial begin
        Reset   = 1'b0;
        Start   = 1'b0;
        Rate    = 2'b00;
        Input   = 1'b0;
        InValid = 1'b0;
        #2;
        check("rst out", 32'(Output), 32'd0);
        check("rst valid", 32'(OutValid), 32'd0);
        check("rst ready", 32'(InReady), 32'd1);
        tick();
        tick();
        #2 Reset = 1'b1;
        tick();

        // rate 1/2 impulse response: 11 01 11 11 00 10 11
        run_stream("r12_imp", 2'b00, 32'b1000000, 7,
                   32'b11011111001011, 32'b10101010101010, 14);
        // rate 1/2 all ones: 11 10 01
        run_stream("r12_ones", 2'b00, 32'b111, 3,
                   32'b111001, 32'b101010, 6);
        // rate 3/4 impulse: 1101 1100, one stall per three accepts
        run_stream("r34_imp", 2'b10, 32'b100000, 6,
                   32'b11011100, 32'b10111011, 8);
        // rate 2/3 impulse: 110 111
        run_stream("r23_imp", 2'b01, 32'b1000, 4,
                   32'b110111, 32'b101101, 6);
        // reserved rate behaves like 1/2
        run_stream("rsv_ones", 2'b11, 32'b111, 3,
                   32'b111001, 32'b101010, 6);

        // Start while a B bit is pending: bit dropped, state and phase cleared
        Start = 1'b1; Rate = 2'b10; InValid = 1'b0;
        tick();
        Start = 1'b0; InValid = 1'b1; Input = 1'b1;
        tick();
        check("sp first_out", 32'(Output), 32'd1);
        check("sp pend_ready", 32'(InReady), 32'd0);
        Start = 1'b1; Rate = 2'b10; InValid = 1'b1; Input = 1'b1;
        #1;
        check("sp start_ready", 32'(InReady), 32'd0);
        tick();
        check("sp dropped_valid", 32'(OutValid), 32'd0);
        Start = 1'b0; InValid = 1'b1; Input = 1'b1;
        #1;
        check("sp ready_again", 32'(InReady), 32'd1);
        tick();
        InValid = 1'b0; Input = 1'b0;
        check("sp a_zero_state", 32'(Output), 32'd1);
        check("sp a_valid", 32'(OutValid), 32'd1);
        tick();
        check("sp b_zero_state", 32'(Output), 32'd1);
        check("sp b_valid", 32'(OutValid), 32'd1);
        tick();
        check("sp idle_valid", 32'(OutValid), 32'd0);

        // asynchronous reset between edges, mid-frame with a pending bit
        Start = 1'b1; Rate = 2'b01;
        tick();
        Start = 1'b0; InValid = 1'b1; Input = 1'b1;
        tick();
        check("ar pre_out", 32'(Output), 32'd1);
        #2 Reset = 1'b0;
        #1;
        check("ar out_now", 32'(Output), 32'd0);
        check("ar valid_now", 32'(OutValid), 32'd0);
        InValid = 1'b0;
        #1;
        check("ar ready_in_reset", 32'(InReady), 32'd1);
        #2 Reset = 1'b1;
        InValid = 1'b1; Input = 1'b0;
        tick();
        InValid = 1'b0;
        // zero-state encoder at default rate 1/2: input 0 -> 00
        check("ar post_a", 32'(Output), 32'd0);
        check("ar post_a_valid", 32'(OutValid), 32'd1);
        tick();
        check("ar post_b", 32'(Output), 32'd0);
        check("ar post_b_valid", 32'(OutValid), 32'd1);
        tick();
        check("ar post_idle", 32'(OutValid), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/conv_encoder_punct.md
CONV_ENCODER_PUNCT -- requirements
Module: conv_encoder_punct

Interface
REQ-001 SHALL have port: Clock  input  1  single clock; all state changes on its rising edge.
REQ-002 SHALL have port: Reset  input  1  asynchronous, active-low; Reset=0 forces reset state immediately, independent of Clock.
REQ-003 SHALL have port: Start  input  1  synchronous frame-start pulse; clears encoder state and latches Rate.
REQ-004 SHALL have port: Rate  input  2  code rate: 00=1/2, 01=2/3, 10=3/4, 11=reserved (treated as 1/2); sampled only when Start=1.
REQ-005 SHALL have port: Input  input  1  uncoded data bit.
REQ-006 SHALL have port: InValid  input  1  Input carries a bit this cycle.
REQ-007 SHALL have port: InReady  output  1  block accepts Input this cycle; InReady = ~Pend & ~Start (combinational).
REQ-008 SHALL have port: Output  output  1  coded bit, registered, serial stream feeding the interleaver.
REQ-009 SHALL have port: OutValid  output  1  Output holds a valid coded bit this cycle (registered).
REQ-010 SHALL have parameters: G0, default 7'o133, generator A; G1, default 7'o171, generator B.

Function
REQ-011 SHALL accept a bit on any rising edge where InValid=1 and InReady=1; no other input is consumed.
REQ-012 SHALL hold a 6-bit shift register s[1..6], where s[d] is the bit accepted d accepts ago.
REQ-013 SHALL compute A = XOR of taps of G0 over {Input,s1..s6} (MSB applies to Input): A = Input^s2^s3^s5^s6; B (G1) = Input^s1^s2^s3^s6.
REQ-014 SHALL on accept shift: s1<=Input, s[d+1]<=s[d]; s6 discarded.
REQ-015 SHALL keep a puncture phase counter, advanced on each accept; modulo 1 (rate 1/2), 2 (2/3), 3 (3/4); wraps to 0.
REQ-016 SHALL apply kept-bit masks per phase: 1/2: {A,B}; 2/3: ph0 {A,B}, ph1 {A}; 3/4: ph0 {A,B}, ph1 {A}, ph2 {B}.
REQ-017 SHALL emit kept bits in order A then B; a phase never keeps zero bits.
REQ-018 SHALL on an accept edge with Pend=0: Output<=first kept bit, OutValid<=1; if two kept, Pend<=1 and PendBit<=B.
REQ-019 SHALL on an edge with Pend=1: Output<=PendBit, OutValid<=1, Pend<=0 (no accept possible, InReady=0).
REQ-020 SHALL on an edge with no accept and Pend=0: OutValid<=0, Output holds its previous value.
REQ-021 SHALL give latency of 1 edge: the A bit of an input accepted at edge t is on Output after edge t.
REQ-022 SHALL give sustained throughput with InValid=1: 1/2 -> 1 input per 2 cycles; 2/3 -> 2 per 3; 3/4 -> 3 per 4; OutValid=1 continuously.
REQ-023 SHALL on Start=1 edge: clear s1..s6, phase, and Pend; set OutValid<=0; latch Rate; Input not accepted that cycle (Start wins over InValid and over a pending bit, which is dropped).
REQ-024 SHALL ignore Rate changes outside Start; the latched rate governs the whole frame.
REQ-025 SHALL NOT insert tail bits; the upstream source supplies 6 zero tail bits per frame.

Reset
REQ-026 SHALL on Reset=0 asynchronously set: s1..s6=0, phase=0, Pend=0, PendBit=0, latched rate=00, Output=0, OutValid=0.
REQ-027 SHALL drive InReady=1 during and after reset when Start=0 (Pend=0).
REQ-028 SHALL on Reset asserted mid-frame discard all pending and shifted bits; first output after release corresponds to a zero-state encoder.

Verification
REQ-029 SHALL pass: reset, Start with Rate=00, impulse 1,0,0,0,0,0,0 -> Output stream 11 01 11 11 00 10 11 with OutValid continuously 1 over 14 cycles.
REQ-030 SHALL pass: Rate=00, all-ones input from zero state, first 3 bits -> 11 10 01; InReady toggles 1,0,1,0,...
REQ-031 SHALL pass: Rate=10, impulse 1,0,0,0,0,0 -> 1101 1100; InReady low exactly one cycle per 3 accepts.
REQ-032 SHALL pass: Rate=01, impulse 1,0,0,0 -> 110 111 (A1 B1 A2 per pair).
REQ-033 SHALL pass: Start asserted while Pend=1 and InValid=1 -> pending bit never appears, OutValid=0 next cycle, next accepted bit encodes from zero state.
REQ-034 SHALL pass: Reset driven low between clock edges mid-frame -> Output=0, OutValid=0 immediately, without waiting for Clock.
